// File: rtl/nibble_adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
// The serial datapath reuses one slice-wide ripple adder.
package nibble_adder_pkg;

  localparam int SIZE_DEF  = 4;
  localparam int WORDS_DEF = 4;
  localparam int IDX_W     = $clog2(WORDS_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int idxWidth(input int words);
    return (words < 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_fa.sv
// Combinational ripple-carry adder, one slice wide.
// Instantiated once by the serial adder and reused every cycle.
module FullAdder4bit #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  output logic [SIZE-1:0] s,
  output logic            cout
);

  logic [SIZE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SIZE; i++) begin : gBit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SIZE];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder built from one slice adder, LSB slice first.
// Carry is registered between slices; valid/ready on both sides.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORDS*SIZE-1:0] a_in,
  input  logic [WORDS*SIZE-1:0] b_in,
  input  logic                  cin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORDS*SIZE-1:0] sum_out,
  output logic                  cout_out,
  output logic                  ovf_out
);

  localparam int W  = WORDS * SIZE;
  localparam int IW = idxWidth(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_t          state;
  logic [IW-1:0]   idx;
  logic [W-1:0]    aSh;
  logic [W-1:0]    bSh;
  logic            carry;
  logic [SIZE-1:0] s;
  logic            cout;
  logic            msbCarry;

  FullAdder4bit #(
    .SIZE(SIZE)
  ) uAdd (
    .a   (aSh[SIZE-1:0]),
    .b   (bSh[SIZE-1:0]),
    .cin (carry),
    .s   (s),
    .cout(cout)
  );

  // Carry into the top bit of the slice, recovered from its sum bit.
  assign msbCarry = aSh[SIZE-1] ^ bSh[SIZE-1] ^ s[SIZE-1];
  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      aSh       <= '0;
      bSh       <= '0;
      carry     <= 1'b0;
      sum_out   <= '0;
      cout_out  <= 1'b0;
      ovf_out   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            aSh   <= a_in;
            bSh   <= b_in;
            carry <= cin_in;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_out[idx*SIZE +: SIZE] <= s;
          carry <= cout;
          aSh   <= aSh >> SIZE;
          bSh   <= bSh >> SIZE;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            cout_out  <= cout;
            ovf_out   <= cout ^ msbCarry;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of the nibble-serial adder
// against a plain-arithmetic reference model.
module tb_nibble_serial_adder;

  localparam int SIZE  = 4;
  localparam int WORDS = 4;
  localparam int W     = SIZE * WORDS;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         inValid = 1'b0;
  logic         inReady;
  logic [W-1:0] aIn = '0;
  logic [W-1:0] bIn = '0;
  logic         cinIn = 1'b0;
  logic         outValid;
  logic         outReady = 1'b1;
  logic [W-1:0] sumOut;
  logic         coutOut;
  logic         ovfOut;

  int checks = 0;
  int failures = 0;

  nibble_serial_adder #(
    .SIZE (SIZE),
    .WORDS(WORDS)
  ) dut (
    .clk      (clk),
    .rst_n    (rstN),
    .in_valid (inValid),
    .in_ready (inReady),
    .a_in     (aIn),
    .b_in     (bIn),
    .cin_in   (cinIn),
    .out_valid(outValid),
    .out_ready(outReady),
    .sum_out  (sumOut),
    .cout_out (coutOut),
    .ovf_out  (ovfOut)
  );

  always #5 clk = ~clk;

  // Returns {ovf, cout, sum}.
  function automatic logic [W+1:0] refModel(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         c
  );
    logic [W:0] full;
    logic       ovf;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkResult(input string tag, input logic [W+1:0] exp);
    check({tag, ".sum"}, 32'(sumOut), 32'(exp[W-1:0]));
    check({tag, ".cout"}, 32'(coutOut), 32'(exp[W]));
    check({tag, ".ovf"}, 32'(ovfOut), 32'(exp[W+1]));
  endtask

  // One operation with out_ready high; checks latency and result.
  task automatic runOp(input string tag, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic c);
    int cyc;
    @(negedge clk);
    check({tag, ".inReady"}, 32'(inReady), 32'd1);
    aIn = a;
    bIn = b;
    cinIn = c;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    cyc = 0;
    while (!outValid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, 32'(cyc), 32'(WORDS));
    checkResult(tag, refModel(a, b, c));
    @(negedge clk);
    check({tag, ".validDrop"}, 32'(outValid), 32'd0);
  endtask

  initial begin
    logic [W+1:0] exp;
    logic [W+1:0] expQ[$];
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int acc1;
    int acc2;
    int nAcc;
    int nGot;
    int cyc;

    // Reset state
    #2;
    check("rst.outValid", 32'(outValid), 32'd0);
    check("rst.sum", 32'(sumOut), 32'd0);
    check("rst.cout", 32'(coutOut), 32'd0);
    check("rst.ovf", 32'(ovfOut), 32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    #1;
    check("rst.inReady", 32'(inReady), 32'd1);

    // Directed boundary cases
    runOp("t1", 16'h00FF, 16'h0001, 1'b0);
    runOp("t2", 16'hFFFF, 16'h0000, 1'b1);
    runOp("t3", 16'h7FFF, 16'h0001, 1'b0);
    runOp("neg", 16'h8000, 16'h8000, 1'b0);

    // Random operations
    for (int i = 0; i < 12; i++) begin
      runOp("rand", 16'($urandom), 16'($urandom), 1'($urandom));
    end

    // Back-pressure
    outReady = 1'b0;
    ra = 16'($urandom);
    rb = 16'($urandom);
    exp = refModel(ra, rb, 1'b1);
    @(negedge clk);
    aIn = ra;
    bIn = rb;
    cinIn = 1'b1;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    cyc = 0;
    while (!outValid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("bp.latency", 32'(cyc), 32'(WORDS));
    for (int i = 0; i < 5; i++) begin
      aIn = 16'($urandom);
      bIn = 16'($urandom);
      inValid = 1'b1;
      @(negedge clk);
      check("bp.hold.valid", 32'(outValid), 32'd1);
      check("bp.hold.inReady", 32'(inReady), 32'd0);
      checkResult("bp.hold", exp);
    end
    inValid = 1'b0;
    outReady = 1'b1;
    @(negedge clk);
    check("bp.release.valid", 32'(outValid), 32'd0);
    check("bp.release.inReady", 32'(inReady), 32'd1);
    checkResult("bp.keep", exp);

    // Reset in the middle of RUN
    @(negedge clk);
    aIn = 16'hABCD;
    bIn = 16'h1111;
    cinIn = 1'b0;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b0;
    #1;
    check("mr.outValid", 32'(outValid), 32'd0);
    check("mr.sum", 32'(sumOut), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    check("mr.inReady", 32'(inReady), 32'd1);
    repeat (WORDS + 2) begin
      @(negedge clk);
      check("mr.noPulse", 32'(outValid), 32'd0);
    end
    runOp("t5", 16'h1234, 16'h4321, 1'b0);

    // Back-to-back with in_valid held high
    ra = 16'($urandom);
    rb = 16'($urandom);
    expQ.push_back(refModel(16'h0F0F, 16'hF0F1, 1'b0));
    expQ.push_back(refModel(ra, rb, 1'b1));
    @(negedge clk);
    aIn = 16'h0F0F;
    bIn = 16'hF0F1;
    cinIn = 1'b0;
    inValid = 1'b1;
    acc1 = -1;
    acc2 = -1;
    nAcc = 0;
    nGot = 0;
    for (int c = 0; c < 40 && nGot < 2; c++) begin
      if (c > 0) @(negedge clk);
      if (outValid) begin
        if (expQ.size() > 0) checkResult("b2b", expQ.pop_front());
        nGot++;
      end
      if (inValid && inReady) begin
        if (nAcc == 0) begin
          acc1 = c;
          @(posedge clk);
          #1;
          aIn = ra;
          bIn = rb;
          cinIn = 1'b1;
        end else begin
          acc2 = c;
          @(posedge clk);
          #1;
          inValid = 1'b0;
        end
        nAcc++;
      end
    end
    inValid = 1'b0;
    check("b2b.results", 32'(nGot), 32'd2);
    check("b2b.spacing", 32'(acc2 - acc1), 32'(WORDS + 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
